// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the Mini SRC hardwired control unit: opcodes, state
// encodings and the instruction-class record produced by the opcode decoder.
package cpu_ctrl_pkg;

    localparam int unsigned OP_LD   = 0;
    localparam int unsigned OP_LDI  = 1;
    localparam int unsigned OP_ST   = 2;
    localparam int unsigned OP_ADD  = 3;
    localparam int unsigned OP_SUB  = 4;
    localparam int unsigned OP_SHR  = 5;
    localparam int unsigned OP_SHRA = 6;
    localparam int unsigned OP_SHL  = 7;
    localparam int unsigned OP_ROR  = 8;
    localparam int unsigned OP_ROL  = 9;
    localparam int unsigned OP_AND  = 10;
    localparam int unsigned OP_OR   = 11;
    localparam int unsigned OP_ADDI = 12;
    localparam int unsigned OP_ANDI = 13;
    localparam int unsigned OP_ORI  = 14;
    localparam int unsigned OP_DIV  = 15;
    localparam int unsigned OP_MUL  = 16;
    localparam int unsigned OP_NEG  = 17;
    localparam int unsigned OP_NOT  = 18;
    localparam int unsigned OP_BR   = 19;
    localparam int unsigned OP_NOP  = 26;
    localparam int unsigned OP_HALT = 27;

    // RST must stay all-zero: step_dbg is required to read 0 during reset.
    localparam logic [3:0] StRst  = 4'd0;
    localparam logic [3:0] StT0   = 4'd1;
    localparam logic [3:0] StT1   = 4'd2;
    localparam logic [3:0] StT2   = 4'd3;
    localparam logic [3:0] StT3   = 4'd4;
    localparam logic [3:0] StT4   = 4'd5;
    localparam logic [3:0] StT5   = 4'd6;
    localparam logic [3:0] StT6   = 4'd7;
    localparam logic [3:0] StT7   = 4'd8;
    localparam logic [3:0] StStop = 4'd9;
    localparam logic [3:0] StHalt = 4'd10;

    typedef struct packed {
        logic alu_r;
        logic alu_i;
        logic unary;
        logic muldiv;
        logic ld;
        logic ldi;
        logic st;
        logic br;
        logic nop;
        logic halt;
    } op_class_t;

endpackage

// File: rtl/opcode_class_decode.sv
// Maps an opcode to a one-hot instruction class; anything undefined raises illegal.
module opcode_class_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    output op_class_t           op_class,
    output logic                illegal
);

    always_comb begin
        op_class = '0;
        illegal  = 1'b0;
        unique case (32'(opcode))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:  op_class.alu_r  = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:         op_class.alu_i  = 1'b1;
            OP_NEG, OP_NOT:                   op_class.unary  = 1'b1;
            OP_MUL, OP_DIV:                   op_class.muldiv = 1'b1;
            OP_LD:                            op_class.ld     = 1'b1;
            OP_LDI:                           op_class.ldi    = 1'b1;
            OP_ST:                            op_class.st     = 1'b1;
            OP_BR:                            op_class.br     = 1'b1;
            OP_NOP:                           op_class.nop    = 1'b1;
            OP_HALT:                          op_class.halt   = 1'b1;
            default:                          illegal         = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: fetch T0-T2, execute T3-T7, with memory-ready
// stalls, stop/resume at instruction boundaries, halt and illegal-opcode handling.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 5,
    parameter int unsigned ALU_OP_W = 5,
    parameter int unsigned STEP_W   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                con_ff,
    input  logic                mem_ready,
    input  logic                stop,
    output logic                pc_out,
    output logic                zhigh_out,
    output logic                zlow_out,
    output logic                mdr_out,
    output logic                ba_out,
    output logic                c_out,
    output logic                r_out,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                ir_in,
    output logic                y_in,
    output logic                z_in,
    output logic                pc_in,
    output logic                r_in,
    output logic                hi_in,
    output logic                lo_in,
    output logic                con_in,
    output logic                gra,
    output logic                grb,
    output logic                grc,
    output logic                inc_pc,
    output logic                mdr_read,
    output logic                mem_write,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                illegal_op,
    output logic [STEP_W-1:0]   step_dbg
);

    logic [3:0] state_q, state_d;
    logic [3:0] boundary;
    op_class_t  cls;
    logic       illegal;
    logic [ALU_OP_W-1:0] op_code, add_code;

    opcode_class_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode   (ir_opcode),
        .op_class (cls),
        .illegal  (illegal)
    );

    assign op_code  = ALU_OP_W'(ir_opcode);
    assign add_code = ALU_OP_W'(OP_ADD);
    // Every path that would re-enter T0 diverts to STOP while a stop is pending.
    assign boundary = stop ? StStop : StT0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst:  state_d = boundary;
            StT0:   state_d = StT1;
            StT1:   state_d = mem_ready ? StT2 : StT1;
            StT2:   state_d = StT3;
            StT3: begin
                if (cls.halt)                 state_d = StHalt;
                else if (cls.nop || illegal)  state_d = boundary;
                else                          state_d = StT4;
            end
            StT4:   state_d = cls.unary ? boundary : StT5;
            StT5:   state_d = (cls.alu_r || cls.alu_i || cls.ldi) ? boundary : StT6;
            StT6: begin
                if (cls.ld)       state_d = mem_ready ? StT7 : StT6;
                else if (cls.st)  state_d = StT7;
                else              state_d = boundary;
            end
            StT7: begin
                if (cls.st) state_d = mem_ready ? boundary : StT7;
                else        state_d = boundary;
            end
            StStop: state_d = stop ? StStop : StT0;
            StHalt: state_d = StHalt;
            default: state_d = StRst;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state_q <= StRst;
        else      state_q <= state_d;
    end

    always_comb begin
        {pc_out, zhigh_out, zlow_out, mdr_out, ba_out, c_out, r_out} = '0;
        {mar_in, mdr_in, ir_in, y_in, z_in, pc_in, r_in, hi_in, lo_in, con_in} = '0;
        {gra, grb, grc, inc_pc, mdr_read, mem_write, illegal_op} = '0;
        alu_op = '0;
        run    = !(state_q == StRst || state_q == StStop || state_q == StHalt);
        case (state_q)
            StT0: {pc_out, mar_in, inc_pc, z_in} = '1;
            StT1: begin
                {zlow_out, mdr_read, mdr_in} = '1;
                pc_in = mem_ready;
            end
            StT2: {mdr_out, ir_in} = '1;
            StT3: begin
                illegal_op = illegal;
                if (cls.alu_r || cls.alu_i) {grb, r_out, y_in} = '1;
                else if (cls.unary) begin
                    {grb, r_out, z_in} = '1;
                    alu_op = op_code;
                end
                else if (cls.muldiv)                   {gra, r_out, y_in} = '1;
                else if (cls.ld || cls.ldi || cls.st)  {grb, ba_out, y_in} = '1;
                else if (cls.br)                       {gra, r_out, con_in} = '1;
            end
            StT4: begin
                if (cls.alu_r || cls.muldiv) begin
                    {r_out, z_in} = '1;
                    grc = cls.alu_r;
                    grb = cls.muldiv;
                    alu_op = op_code;
                end else if (cls.alu_i) begin
                    {c_out, z_in} = '1;
                    alu_op = op_code;
                end else if (cls.unary) begin
                    {zlow_out, gra, r_in} = '1;
                end else if (cls.ld || cls.ldi || cls.st) begin
                    {c_out, z_in} = '1;
                    alu_op = add_code;
                end else if (cls.br) begin
                    {pc_out, y_in} = '1;
                end
            end
            StT5: begin
                if (cls.alu_r || cls.alu_i || cls.ldi) {zlow_out, gra, r_in} = '1;
                else if (cls.muldiv)                   {zlow_out, lo_in} = '1;
                else if (cls.ld || cls.st)             {zlow_out, mar_in} = '1;
                else if (cls.br) begin
                    {c_out, z_in} = '1;
                    alu_op = add_code;
                end
            end
            StT6: begin
                if (cls.muldiv)  {zhigh_out, hi_in} = '1;
                else if (cls.ld) {mdr_read, mdr_in} = '1;
                else if (cls.st) {gra, r_out, mdr_in} = '1;
                else if (cls.br) begin
                    zlow_out = 1'b1;
                    pc_in    = con_ff;
                end
            end
            StT7: begin
                if (cls.ld)      {mdr_out, gra, r_in} = '1;
                else if (cls.st) mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign step_dbg = STEP_W'(state_q);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: a queue of expected micro-steps per
// instruction is built from the instruction tables and compared every cycle.
module tb_control_sequencer;
    import cpu_ctrl_pkg::*;

    logic clk = 1'b0;
    logic clr, con_ff, mem_ready, stop;
    logic [4:0] ir_opcode;
    logic pc_out, zhigh_out, zlow_out, mdr_out, ba_out, c_out, r_out;
    logic mar_in, mdr_in, ir_in, y_in, z_in, pc_in, r_in, hi_in, lo_in, con_in;
    logic gra, grb, grc, inc_pc, mdr_read, mem_write, run, illegal_op;
    logic [4:0] alu_op;
    logic [3:0] step_dbg;

    control_sequencer dut (
        .clk(clk), .clr(clr), .ir_opcode(ir_opcode), .con_ff(con_ff),
        .mem_ready(mem_ready), .stop(stop),
        .pc_out(pc_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out), .mdr_out(mdr_out),
        .ba_out(ba_out), .c_out(c_out), .r_out(r_out), .mar_in(mar_in), .mdr_in(mdr_in),
        .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .pc_in(pc_in), .r_in(r_in),
        .hi_in(hi_in), .lo_in(lo_in), .con_in(con_in), .gra(gra), .grb(grb), .grc(grc),
        .inc_pc(inc_pc), .mdr_read(mdr_read), .mem_write(mem_write), .alu_op(alu_op),
        .run(run), .illegal_op(illegal_op), .step_dbg(step_dbg)
    );

    always #5 clk = ~clk;

    localparam logic [22:0] PC_OUT = 23'd1 << 22, ZHIGH = 23'd1 << 21, ZLOW = 23'd1 << 20;
    localparam logic [22:0] MDR_OUT = 23'd1 << 19, BA_OUT = 23'd1 << 18, C_OUT = 23'd1 << 17;
    localparam logic [22:0] R_OUT = 23'd1 << 16, MAR_IN = 23'd1 << 15, MDR_IN = 23'd1 << 14;
    localparam logic [22:0] IR_IN = 23'd1 << 13, Y_IN = 23'd1 << 12, Z_IN = 23'd1 << 11;
    localparam logic [22:0] PC_IN = 23'd1 << 10, R_IN = 23'd1 << 9, HI_IN = 23'd1 << 8;
    localparam logic [22:0] LO_IN = 23'd1 << 7, CON_IN = 23'd1 << 6, GRA = 23'd1 << 5;
    localparam logic [22:0] GRB = 23'd1 << 4, GRC = 23'd1 << 3, INC_PC = 23'd1 << 2;
    localparam logic [22:0] MDR_READ = 23'd1 << 1, MEM_WRITE = 23'd1;

    localparam int MRun = 0, MStop = 1, MHalt = 2, MRst = 3;

    logic [22:0] strobes;
    logic [33:0] all_out;
    assign strobes = {pc_out, zhigh_out, zlow_out, mdr_out, ba_out, c_out, r_out, mar_in,
                      mdr_in, ir_in, y_in, z_in, pc_in, r_in, hi_in, lo_in, con_in,
                      gra, grb, grc, inc_pc, mdr_read, mem_write};
    assign all_out = {strobes, run, illegal_op, alu_op, step_dbg};

    // pcin: 0 never, 1 follows mem_ready, 2 follows con_ff
    typedef struct {
        logic [22:0] mask;
        int          t;
        bit          wait_mem;
        int          pcin;
        logic [4:0]  aop;
        bit          ill;
        bit          halt;
    } step_t;

    step_t q[$];
    int    prog[$];
    int    mode, halt_cnt;
    int    n_checks = 0, n_fail = 0;
    logic [4:0] cur_op;
    bit    st_rst_done = 0, rel_pending = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [22:0] m, input int t, input bit w = 0, input int pcin = 0,
                        input logic [4:0] aop = 5'd0, input bit ill = 0, input bit h = 0);
        step_t s;
        s.mask = m; s.t = t; s.wait_mem = w; s.pcin = pcin;
        s.aop = aop; s.ill = ill; s.halt = h;
        q.push_back(s);
    endtask

    task automatic start_instr();
        logic [4:0] add5;
        add5 = 5'(OP_ADD);
        cur_op = (prog.size() != 0) ? 5'(prog.pop_front()) : 5'($urandom_range(0, 31));
        mode = MRun;
        q.delete();
        push(PC_OUT | MAR_IN | INC_PC | Z_IN, 0);
        push(ZLOW | MDR_READ | MDR_IN, 1, 1, 1);
        push(MDR_OUT | IR_IN, 2);
        case (int'(cur_op))
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                push(GRB | R_OUT | Y_IN, 3);
                push(GRC | R_OUT | Z_IN, 4, 0, 0, cur_op);
                push(ZLOW | GRA | R_IN, 5);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                push(GRB | R_OUT | Y_IN, 3);
                push(C_OUT | Z_IN, 4, 0, 0, cur_op);
                push(ZLOW | GRA | R_IN, 5);
            end
            OP_NEG, OP_NOT: begin
                push(GRB | R_OUT | Z_IN, 3, 0, 0, cur_op);
                push(ZLOW | GRA | R_IN, 4);
            end
            OP_MUL, OP_DIV: begin
                push(GRA | R_OUT | Y_IN, 3);
                push(GRB | R_OUT | Z_IN, 4, 0, 0, cur_op);
                push(ZLOW | LO_IN, 5);
                push(ZHIGH | HI_IN, 6);
            end
            OP_LD, OP_LDI, OP_ST: begin
                push(GRB | BA_OUT | Y_IN, 3);
                push(C_OUT | Z_IN, 4, 0, 0, add5);
                if (int'(cur_op) == OP_LDI) push(ZLOW | GRA | R_IN, 5);
                else push(ZLOW | MAR_IN, 5);
                if (int'(cur_op) == OP_LD) begin
                    push(MDR_READ | MDR_IN, 6, 1);
                    push(MDR_OUT | GRA | R_IN, 7);
                end else if (int'(cur_op) == OP_ST) begin
                    push(GRA | R_OUT | MDR_IN, 6);
                    push(MEM_WRITE, 7, 1);
                end
            end
            OP_BR: begin
                push(GRA | R_OUT | CON_IN, 3);
                push(PC_OUT | Y_IN, 4);
                push(C_OUT | Z_IN, 5, 0, 0, add5);
                push(ZLOW, 6, 0, 2);
            end
            OP_NOP:  push(23'd0, 3);
            OP_HALT: push(23'd0, 3, 0, 0, 5'd0, 0, 1);
            default: push(23'd0, 3, 0, 0, 5'd0, 1);
        endcase
    endtask

    task automatic at_boundary();
        if (stop) mode = MStop;
        else start_instr();
    endtask

    function automatic logic [3:0] t_code(input int t);
        case (t)
            0: return StT0;
            1: return StT1;
            2: return StT2;
            3: return StT3;
            4: return StT4;
            5: return StT5;
            6: return StT6;
            default: return StT7;
        endcase
    endfunction

    initial begin
        logic [22:0] e_mask;
        logic [4:0]  e_aop;
        logic        e_run, e_ill;
        logic [3:0]  e_step;
        step_t       h;
        bit          inj, st_case;

        prog = '{OP_ANDI, OP_LD, OP_BR, OP_BR, OP_ADD, 31, OP_ST, OP_MUL, OP_NEG, OP_LDI,
                 OP_ST, OP_NOP, OP_HALT};
        clr = 1'b0; con_ff = 1'b0; mem_ready = 1'b1; stop = 1'b0; ir_opcode = '0;
        repeat (2) @(posedge clk);
        #1 check_eq("reset_outputs", 64'(all_out), 64'd0);
        mode = MRst;
        rel_pending = 1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (rel_pending) begin
                clr = 1'b1;
                rel_pending = 0;
            end
            mem_ready = ($urandom_range(0, 9) < 6);
            con_ff    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) stop = ~stop;
            if (mode == MRst) stop = 1'b0;
            if (mode == MRun && q.size() != 0 && q[0].t >= 3) ir_opcode = cur_op;
            else ir_opcode = 5'($urandom);

            st_case = (mode == MRun && q.size() != 0 && int'(cur_op) == OP_ST &&
                       q[0].t == 6 && !st_rst_done);
            inj = st_case || (mode == MHalt && halt_cnt >= 4) ||
                  (mode == MRun && $urandom_range(0, 199) == 0);
            if (inj) begin
                if (st_case) st_rst_done = 1;
                #1 clr = 1'b0;
                #1 check_eq("async_reset_outputs", 64'(all_out), 64'd0);
                mode = MRst;
                q.delete();
                rel_pending = 1;
                continue;
            end

            @(negedge clk);
            e_mask = '0; e_aop = '0; e_run = 1'b0; e_ill = 1'b0;
            case (mode)
                MRun: begin
                    h = q[0];
                    e_mask = h.mask;
                    if ((h.pcin == 1 && mem_ready) || (h.pcin == 2 && con_ff)) e_mask |= PC_IN;
                    e_aop  = h.aop;
                    e_run  = 1'b1;
                    e_ill  = h.ill;
                    e_step = t_code(h.t);
                end
                MStop:   e_step = StStop;
                MHalt:   e_step = StHalt;
                default: e_step = StRst;
            endcase
            check_eq("strobes", 64'(strobes), 64'(e_mask));
            check_eq("alu_op", 64'(alu_op), 64'(e_aop));
            check_eq("run", 64'(run), 64'(e_run));
            check_eq("illegal_op", 64'(illegal_op), 64'(e_ill));
            check_eq("step_dbg", 64'(step_dbg), 64'(e_step));

            case (mode)
                MRun: begin
                    if (!(q[0].wait_mem && !mem_ready)) begin
                        h = q.pop_front();
                        if (h.halt) begin
                            mode = MHalt;
                            halt_cnt = 0;
                            q.delete();
                        end else if (q.size() == 0) begin
                            at_boundary();
                        end
                    end
                end
                MStop: if (!stop) start_instr();
                MHalt: halt_cnt++;
                default: at_boundary();
            endcase
        end

        if (!st_rst_done) check_eq("st_t6_reset_reached", 64'(st_rst_done), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
